spi_frame_master: RTL and testbench

Single-clock SPI frame initiator that drives the slave-side SS_n/MOSI/MISO link of the SPI-RAM subsystem. It accepts a 10-bit command word from a host, serialises it in the exact frame format the SPI slave decodes (command-select bit, then 10 bits MSB first), and for read-data commands collects the 8-bit MISO reply. The master and slave share one clock; there is no separate SCLK, and one bit moves per `clk` cycle.

---
 rtl/spi_frame_master.sv | 117 +++++++++++
 tb/tb_spi_frame_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// SPI frame initiator: select bit plus 10-bit command, MSB first.
// Read-data frames wait RD_LAT cycles, then collect one MISO byte.
module spi_frame_master #(
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] cmd,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_CMD,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_END
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

  state_t     state;
  logic [9:0] cmd_q;
  logic [8:0] sh;
  logic [6:0] rx;
  logic [3:0] cnt;

  // Outputs are loaded with the value of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cmd_q   <= '0;
      sh      <= '0;
      rx      <= '0;
      cnt     <= '0;
      SS_n    <= 1'b1;
      MOSI    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            cmd_q <= cmd;
            SS_n  <= 1'b0;
            MOSI  <= 1'b0;
            busy  <= 1'b1;
            state <= ST_SEL;
          end
        end
        ST_SEL: begin
          MOSI  <= cmd_q[9];
          state <= ST_CMD;
        end
        ST_CMD: begin
          MOSI  <= cmd_q[9];
          sh    <= cmd_q[8:0];
          cnt   <= '0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt == 4'd9) begin
            MOSI <= 1'b0;
            cnt  <= '0;
            if (cmd_q[9:8] == 2'b11) begin
              state <= ST_WAIT;
            end else begin
              SS_n  <= 1'b1;
              done  <= 1'b1;
              state <= ST_END;
            end
          end else begin
            MOSI <= sh[8];
            sh   <= {sh[7:0], 1'b0};
            cnt  <= cnt + 4'd1;
          end
        end
        ST_WAIT: begin
          if (cnt == LAT_LAST) begin
            cnt   <= '0;
            state <= ST_RECV;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RECV: begin
          rx <= {rx[5:0], MISO};
          if (cnt == 4'd7) begin
            rd_data <= {rx, MISO};
            SS_n    <= 1'b1;
            done    <= 1'b1;
            cnt     <= '0;
            state   <= ST_END;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_END: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master with RD_LAT=2 and RD_LAT=3.
// A slave/RAM model drives MISO by frame cycle; frames are recorded per cycle.
module tb_spi_frame_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start2, start3;
  logic [9:0] cmd_r;
  logic       busy2, done2, ss2, mosi2, miso2;
  logic       busy3, done3, ss3, mosi3, miso3;
  logic [7:0] rd2, rd3;
  logic [7:0] ram2, ram3;
  int         f2, f3;
  int         n_chk, n_fail;

  always #5 clk = ~clk;

  spi_frame_master #(.RD_LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .cmd(cmd_r),
    .busy(busy2), .done(done2), .rd_data(rd2),
    .SS_n(ss2), .MOSI(mosi2), .MISO(miso2)
  );

  spi_frame_master #(.RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .cmd(cmd_r),
    .busy(busy3), .done(done3), .rd_data(rd3),
    .SS_n(ss3), .MOSI(mosi3), .MISO(miso3)
  );

  // Frame cycle index: equals k during frame cycle Fk.
  always @(posedge clk) begin
    f2 <= busy2 ? f2 + 1 : 0;
    f3 <= busy3 ? f3 + 1 : 0;
  end

  // RAM reply: byte MSB first in the RECV window, zero elsewhere.
  always_comb begin
    miso2 = 1'b0;
    miso3 = 1'b0;
    if (f2 >= 14 && f2 <= 21) miso2 = ram2[21-f2];
    if (f3 >= 15 && f3 <= 22) miso3 = ram3[22-f3];
  end

  logic       ss[48], mo[48], dn[48], bz[48];
  logic [7:0] rd[48];

  typedef struct {
    logic [9:0] cmd;
    logic [7:0] ram;
    int         len;
    int         dat;
    logic [7:0] rdx;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int low_len();
    int n = 0;
    for (int k = 0; k < 48; k++) begin
      if (ss[k] !== 1'b0) break;
      n++;
    end
    return n;
  endfunction

  function automatic int done_at();
    for (int k = 0; k < 40; k++) if (dn[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int done_cnt();
    int n = 0;
    for (int k = 0; k < 40; k++) if (dn[k] === 1'b1) n++;
    return n;
  endfunction

  function automatic logic [10:0] mseq(input int base);
    logic [10:0] s = '0;
    for (int k = 1; k <= 11; k++) s = {s[9:0], mo[base+k]};
    return s;
  endfunction

  function automatic logic mosi_tail(input int last);
    logic t = 1'b0;
    for (int k = 12; k <= last; k++) t = t | mo[k];
    return t;
  endfunction

  task automatic run_frame(input logic which, input logic [9:0] c,
                           input logic hold, input int inj_k,
                           input logic [9:0] ic, input int rst_k);
    @(negedge clk);
    cmd_r = c;
    if (which) start3 = 1'b1;
    else start2 = 1'b1;
    @(negedge clk);
    if (!hold) begin
      start2 = 1'b0;
      start3 = 1'b0;
    end
    for (int k = 0; k < 40; k++) begin
      if (k == inj_k + 1) start2 = 1'b0;
      if (k == rst_k + 1) rst = 1'b0;
      ss[k] = which ? ss3 : ss2;
      mo[k] = which ? mosi3 : mosi2;
      dn[k] = which ? done3 : done2;
      bz[k] = which ? busy3 : busy2;
      rd[k] = which ? rd3 : rd2;
      if (k == inj_k) begin
        cmd_r  = ic;
        start2 = 1'b1;
      end
      if (k == rst_k) rst = 1'b1;
      @(negedge clk);
    end
    start2 = 1'b0;
    start3 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy2 && !busy3) break;
      @(negedge clk);
    end
    if (busy2 || busy3) chk("idle_timeout", 1, 0);
  endtask

  int da, gap;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    start2 = 1'b0;
    start3 = 1'b0;
    cmd_r = '0;
    ram2 = 8'h00;
    ram3 = 8'h00;
    tv[0] = '{10'h0A5, 8'h00, 12, 12, 8'h00};
    tv[1] = '{10'h2C3, 8'h00, 12, 12, 8'h00};
    tv[2] = '{10'h300, 8'hB6, 22, 22, 8'hB6};
    tv[3] = '{10'h17F, 8'h00, 12, 12, 8'hB6};
    tv[4] = '{10'h3A1, 8'h5A, 22, 22, 8'h5A};

    repeat (3) @(negedge clk);
    chk("rst_ss", ss2, 1);
    chk("rst_mosi", mosi2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_rd", rd2, 0);

    start2 = 1'b1;
    cmd_r = 10'h0A5;
    @(negedge clk);
    chk("rst_start_busy", busy2, 0);
    chk("rst_start_ss", ss2, 1);
    rst = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    chk("rst_start_idle", busy2, 0);

    // Hand-derived bit stream for 10'b00_1010_0101.
    run_frame(0, 10'h0A5, 0, 100, 0, 100);
    chk("wa_bits", mseq(0), 11'b00010100101);

    for (int i = 0; i < 5; i++) begin
      ram2 = tv[i].ram;
      run_frame(0, tv[i].cmd, 0, 100, 0, 100);
      da = done_at();
      chk($sformatf("v%0d_len", i), low_len(), tv[i].len);
      chk($sformatf("v%0d_done_at", i), da, tv[i].dat);
      chk($sformatf("v%0d_done_cnt", i), done_cnt(), 1);
      chk($sformatf("v%0d_bits", i), mseq(0), {tv[i].cmd[9], tv[i].cmd});
      chk($sformatf("v%0d_tail", i), mosi_tail(tv[i].len), 0);
      if (da >= 0) begin
        chk($sformatf("v%0d_rd", i), rd[da], tv[i].rdx);
        chk($sformatf("v%0d_hold", i), rd[da+3], tv[i].rdx);
        chk($sformatf("v%0d_busy_end", i), bz[da+1], 0);
      end
    end

    ram3 = 8'hC3;
    run_frame(1, 10'h300, 0, 100, 0, 100);
    da = done_at();
    chk("lat3_len", low_len(), 23);
    chk("lat3_done_at", da, 23);
    chk("lat3_tail", mosi_tail(23), 0);
    if (da >= 0) chk("lat3_rd", rd[da], 8'hC3);

    run_frame(0, 10'h0A5, 0, 5, 10'h155, 100);
    chk("rej_bits", mseq(0), 11'b00010100101);
    chk("rej_done_cnt", done_cnt(), 1);
    chk("rej_len", low_len(), 12);
    gap = 0;
    for (int k = 12; k < 40; k++) if (ss[k] !== 1'b1) gap++;
    chk("rej_no_frame", gap, 0);

    run_frame(0, 10'h17F, 1, 100, 0, 100);
    chk("b2b_len", low_len(), 12);
    gap = 0;
    for (int k = 12; k < 40 && ss[k] === 1'b1; k++) gap++;
    chk("b2b_gap1", gap, 2);
    gap = 0;
    for (int k = 26; k < 40 && ss[k] === 1'b1; k++) gap++;
    chk("b2b_gap2", gap, 2);
    chk("b2b_rx1", mseq(0), {1'b0, 10'h17F});
    chk("b2b_rx2", mseq(14), {1'b0, 10'h17F});
    chk("b2b_rx3", mseq(28), {1'b0, 10'h17F});

    ram2 = 8'hB6;
    run_frame(0, 10'h300, 0, 100, 0, 7);
    chk("rmid_pre_rd", rd[7], 8'h5A);
    chk("rmid_ss", ss[8], 1);
    chk("rmid_busy", bz[8], 0);
    chk("rmid_done", dn[8], 0);
    chk("rmid_rd", rd[8], 0);
    chk("rmid_done_cnt", done_cnt(), 0);

    run_frame(0, 10'h0A5, 0, 100, 0, 100);
    chk("post_len", low_len(), 12);
    chk("post_done_at", done_at(), 12);
    chk("post_bits", mseq(0), 11'b00010100101);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
